// File: rtl/crc_hash_stage.sv
// crc_hash_stage: two-stage ready/valid pipelined hasher for a Bloom-filter
// bit array. Stage 1 registers the input string; HASHES_CNT CRC lanes hash
// it combinationally (each lane starts from its own initial value); stage 2
// registers the hashes together with the string that produced them.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   data_i / valid_i / ready_o input string handshake (byte k = [k*BYTE_W +: BYTE_W])
//   hashes_o                  hash n = [n*HASH_W +: HASH_W]
//   data_o                    string that produced hashes_o
//   hashes_data_valid_o / hashes_data_ready_i  output handshake

// Bit-serial CRC over the whole string, unrolled into combinational logic.
// Bytes are consumed from index STR_SIZE-1 down to 0, each MSB first, which
// is simply the flat data word from its MSB to its LSB.
module crc_hash_lane #(
  parameter int          BYTE_W   = 8,
  parameter int          STR_SIZE = 6,
  parameter int          HASH_W   = 13,
  parameter logic [31:0] POLY     = 32'h1CF5,
  parameter logic [31:0] INIT     = 32'h0
) (
  input  logic [STR_SIZE*BYTE_W-1:0] i_data,
  output logic [HASH_W-1:0]          o_hash
);
  localparam logic [HASH_W-1:0] P  = POLY[HASH_W-1:0];
  localparam logic [HASH_W-1:0] C0 = INIT[HASH_W-1:0];

  logic [HASH_W-1:0] w_c;
  logic              w_fb;

  always_comb begin
    w_c  = C0;
    w_fb = 1'b0;
    for (int k = STR_SIZE - 1; k >= 0; k--) begin
      for (int b = BYTE_W - 1; b >= 0; b--) begin
        w_fb = w_c[HASH_W-1] ^ i_data[k*BYTE_W + b];
        w_c  = w_c << 1;
        if (w_fb) w_c = w_c ^ P;
      end
    end
  end

  assign o_hash = w_c;
endmodule

module crc_hash_stage #(
  parameter int          BYTE_W     = 8,
  parameter int          STR_SIZE   = 6,
  parameter int          HASHES_CNT = 12,
  parameter int          HASH_W     = 13,
  parameter logic [31:0] POLY       = 32'h1CF5,
  parameter logic [31:0] INIT_SEED  = 32'h0,
  parameter logic [31:0] INIT_STEP  = 32'h0A5
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [STR_SIZE*BYTE_W-1:0]   data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [HASHES_CNT*HASH_W-1:0] hashes_o,
  output logic [STR_SIZE*BYTE_W-1:0]   data_o,
  output logic                         hashes_data_valid_o,
  input  logic                         hashes_data_ready_i
);
  localparam int DW = STR_SIZE * BYTE_W;

  if (HASH_W > 32 || HASH_W < 1 || HASHES_CNT > 16 || HASHES_CNT < 1) begin : g_bad_params
    $fatal(1, "crc_hash_stage: HASH_W must be 1..32 and HASHES_CNT 1..16");
  end

  logic                                 r_v1, r_v2;
  logic [DW-1:0]                        r_d1, r_d2;
  logic [HASHES_CNT-1:0][HASH_W-1:0]    r_h2;
  logic [HASHES_CNT-1:0][HASH_W-1:0]    w_hashes;
  logic                                 w_r1;

  // Each stage accepts when empty or when its contents leave this cycle,
  // so a full pipe with downstream ready still streams one string per clock.
  assign w_r1    = !r_v2 || hashes_data_ready_i;
  assign ready_o = !r_v1 || w_r1;

  for (genvar n = 0; n < HASHES_CNT; n++) begin : g_lane
    localparam logic [31:0] LANE_INIT = INIT_SEED ^ (32'(n) * INIT_STEP);
    crc_hash_lane #(
      .BYTE_W  (BYTE_W),
      .STR_SIZE(STR_SIZE),
      .HASH_W  (HASH_W),
      .POLY    (POLY),
      .INIT    (LANE_INIT)
    ) u_lane (
      .i_data(r_d1),
      .o_hash(w_hashes[n])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else if (ready_o) begin
      r_v1 <= valid_i;
      if (valid_i) r_d1 <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v2 <= 1'b0;
      r_d2 <= '0;
      r_h2 <= '0;
    end else if (w_r1) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_d2 <= r_d1;
        r_h2 <= w_hashes;
      end
    end
  end

  assign data_o              = r_d2;
  assign hashes_o            = r_h2;
  assign hashes_data_valid_o = r_v2;
endmodule

// File: tb/tb_crc_hash_stage.sv
module tb_crc_hash_stage;
  localparam int          BW   = 8;
  localparam int          SS   = 6;
  localparam int          HC   = 12;
  localparam int          HW   = 13;
  localparam int          DW   = BW * SS;
  localparam logic [31:0] POLY = 32'h1CF5;
  localparam logic [31:0] SEED = 32'h0;
  localparam logic [31:0] STEP = 32'h0A5;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic [DW-1:0]       data_i;
  logic                valid_i;
  logic                ready_o;
  logic [HC*HW-1:0]    hashes_o;
  logic [DW-1:0]       data_o;
  logic                hashes_data_valid_o;
  logic                hashes_data_ready_i;

  crc_hash_stage #(
    .BYTE_W(BW), .STR_SIZE(SS), .HASHES_CNT(HC), .HASH_W(HW),
    .POLY(POLY), .INIT_SEED(SEED), .INIT_STEP(STEP)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .hashes_o(hashes_o), .data_o(data_o),
    .hashes_data_valid_o(hashes_data_valid_o),
    .hashes_data_ready_i(hashes_data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk = 0, n_err = 0, cyc = 0, n_acc = 0;
  logic [DW-1:0] q_d[$];
  int            q_c[$];
  bit            lat_mode = 1'b0;
  bit            stalled = 1'b0;
  logic [DW-1:0] held_d;
  logic [HC*HW-1:0] held_h;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as polynomial remainder: (init * x^L + M * x^HW) mod P over GF(2),
  // where M is the string read MSB-first as one L-bit number.
  function automatic logic [HW-1:0] ref_crc(input logic [DW-1:0] d, input int n);
    logic [HW-1:0] init;
    logic [127:0]  r, p;
    logic [31:0]   full_init;
    full_init = SEED ^ (32'(n) * STEP);
    init = full_init[HW-1:0];
    p = (128'(1) << HW) | 128'(POLY[HW-1:0]);
    r = (128'(init) << DW) ^ (128'(d) << HW);
    for (int i = DW + HW - 1; i >= HW; i--)
      if (r[i]) r = r ^ (p << (i - HW));
    return r[HW-1:0];
  endfunction

  // One clock: sample shortly after the falling edge (well before the next
  // rising edge), score both handshakes, then return at the next falling edge.
  task automatic cycle();
    logic [DW-1:0] d;
    int c;
    #1;
    if (rst_n_i) begin
      check("ready_o", 64'(ready_o), 64'((q_d.size() < 2) || hashes_data_ready_i));
      if (q_d.size() == 0) check("valid_idle", 64'(hashes_data_valid_o), 64'(0));
      if (stalled) begin
        check("hold_data", 64'(data_o), 64'(held_d));
        check("hold_valid", 64'(hashes_data_valid_o), 64'(1));
        for (int n = 0; n < HC; n++)
          check("hold_hash", 64'(hashes_o[n*HW +: HW]), 64'(held_h[n*HW +: HW]));
      end
      if (hashes_data_valid_o && hashes_data_ready_i) begin
        if (q_d.size() == 0) check("out_without_in", 64'(hashes_data_valid_o), 64'(0));
        else begin
          d = q_d.pop_front();
          c = q_c.pop_front();
          check("data_o", 64'(data_o), 64'(d));
          for (int n = 0; n < HC; n++)
            check("hash", 64'(hashes_o[n*HW +: HW]), 64'(ref_crc(d, n)));
          if (lat_mode) check("latency", 64'(cyc - c), 64'(2));
        end
      end
      if (valid_i && ready_o) begin
        q_d.push_back(data_i);
        q_c.push_back(cyc);
        n_acc++;
      end
      stalled = hashes_data_valid_o && !hashes_data_ready_i;
      held_d  = data_o;
      held_h  = hashes_o;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic check_reset_state();
    check("rst_valid", 64'(hashes_data_valid_o), 64'(0));
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_hashes_lo", 64'(hashes_o[63:0]), 64'(0));
    check("rst_hashes_hi", 64'(hashes_o[HC*HW-1:64]), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(1));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    hashes_data_ready_i = 1'b1;
    data_i = '0;
    #1;
    check_reset_state();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    lat_mode = 1'b1;

    // Directed: all-zero string and the string 1.
    valid_i = 1'b1; data_i = '0;         cycle();
    data_i = DW'(1);                      cycle();
    valid_i = 1'b0;
    #1;
    check("h0_zero", 64'(hashes_o[HW-1:0]), 64'(13'h0000));
    check("echo_zero", 64'(data_o), 64'(0));
    cycle();
    #1;
    check("h0_poly", 64'(hashes_o[HW-1:0]), 64'(13'h1CF5));
    check("echo_one", 64'(data_o), 64'(1));
    check("hash_n_differ", 64'(hashes_o[HW-1:0] != hashes_o[2*HW-1:HW]), 64'(1));
    cycle();
    cycle();

    // Stream of 20 strings at full rate.
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1; data_i = rnd_data(); cycle();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("stream_drained", 64'(q_d.size()), 64'(0));

    // Backpressure: pipe empty, downstream stalls 5 cycles with input offered.
    lat_mode = 1'b0;
    n_acc = 0;
    hashes_data_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = rnd_data(); cycle();
    end
    check("bp_accepts", 64'(n_acc), 64'(2));
    check("bp_ready_low", 64'(ready_o), 64'(0));
    hashes_data_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(ready_o), 64'(1));
    cycle();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("bp_drained", 64'(q_d.size()), 64'(0));

    // Random traffic with a reset dropped into the middle.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        valid_i = 1'b1; hashes_data_ready_i = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check_reset_state();
        q_d.delete(); q_c.delete();
        stalled = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        lat_mode = 1'b1;
      end
      if (i == 5020) lat_mode = 1'b0;
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = rnd_data();
      hashes_data_ready_i = lat_mode ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle();
    end
    valid_i = 1'b0; hashes_data_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("final_drained", 64'(q_d.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
